// File: rtl/store_merge_rmw_if.sv
// Store-merge bus bundle: the core-side store request plus the word-wide memory port.
// The slave view belongs to the merge unit; the master view belongs to the core and memory side.
interface store_merge_rmw_if #(
    parameter int XLEN = 64,
    parameter int AW   = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_wdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_wr_en;
    logic [XLEN-1:0] mem_wdata;
    logic            done;
    logic            err;

    modport slave (
        input  req_valid, req_addr, req_size, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );

    modport master (
        output req_valid, req_addr, req_size, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );
endinterface

// File: rtl/store_merge_rmw.sv
// Sequential store-merge unit: partial stores do a read-modify-write of the containing
// memory word, full-word stores bypass the read, misaligned/oversized stores are rejected.
module store_merge_rmw #(
    parameter int XLEN   = 64,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    store_merge_rmw_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int MAXSZ = OFF_W;
    localparam int CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     addr_reg, addr_next;
    logic [1:0]        size_reg, size_next;
    logic [OFF_W-1:0]  off_reg, off_next;
    logic [XLEN-1:0]   wdata_reg, wdata_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              ready_reg, ready_next;
    logic              rd_en_reg, rd_en_next;
    logic              wr_en_reg, wr_en_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [AW-1:0]     mem_addr_reg, mem_addr_next;
    logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;

    logic [OFF_W-1:0]  req_off;
    logic [AW-1:0]     req_word;
    logic [OFF_W-1:0]  align_bad;
    logic              req_reject;
    logic [XLEN-1:0]   shifted;
    logic [NB-1:0]     lane_sel;
    logic [XLEN-1:0]   merged;

    assign req_off  = bus.req_addr[OFF_W-1:0];
    assign req_word = {bus.req_addr[AW-1:OFF_W], {OFF_W{1'b0}}};

    // An offset bit below the store size being set means the store is not naturally aligned.
    genvar gi;
    generate
        for (gi = 0; gi < OFF_W; gi++) begin : g_align
            assign align_bad[gi] = bus.req_addr[gi] & (gi < int'(bus.req_size));
        end
    endgenerate

    assign req_reject = (int'(bus.req_size) > MAXSZ) || (|align_bad);

    // Store bytes move up to their lane; only lanes inside the store window take them.
    assign shifted = wdata_reg << {off_reg, 3'b000};

    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_sel[gi] = (gi >= int'(off_reg)) &&
                                  (gi < int'(off_reg) + (1 << size_reg));
            assign merged[8*gi +: 8] = lane_sel[gi] ? shifted[8*gi +: 8]
                                                    : bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        size_next      = size_reg;
        off_next       = off_reg;
        wdata_next     = wdata_reg;
        cnt_next       = cnt_reg;
        ready_next     = 1'b0;
        rd_en_next     = 1'b0;
        wr_en_next     = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (bus.req_valid && ready_reg) begin
                    addr_next  = req_word;
                    size_next  = bus.req_size;
                    off_next   = req_off;
                    wdata_next = bus.req_wdata;
                    ready_next = 1'b0;
                    if (req_reject) begin
                        state_next = RESP;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else if (int'(bus.req_size) == MAXSZ) begin
                        state_next     = WRITE;
                        wr_en_next     = 1'b1;
                        done_next      = 1'b1;
                        mem_addr_next  = req_word;
                        mem_wdata_next = bus.req_wdata;
                    end else begin
                        state_next    = READ;
                        rd_en_next    = 1'b1;
                        mem_addr_next = req_word;
                    end
                end
            end
            READ: begin
                state_next = WAIT;
                cnt_next   = CW'(RD_LAT - 1);
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    state_next     = WRITE;
                    wr_en_next     = 1'b1;
                    done_next      = 1'b1;
                    mem_addr_next  = addr_reg;
                    mem_wdata_next = merged;
                end
            end
            WRITE, RESP: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            size_reg      <= '0;
            off_reg       <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            ready_reg     <= 1'b1;
            rd_en_reg     <= 1'b0;
            wr_en_reg     <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            size_reg      <= size_next;
            off_reg       <= off_next;
            wdata_reg     <= wdata_next;
            cnt_reg       <= cnt_next;
            ready_reg     <= ready_next;
            rd_en_reg     <= rd_en_next;
            wr_en_reg     <= wr_en_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.mem_rd_en = rd_en_reg;
    assign bus.mem_wr_en = wr_en_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_store_merge_rmw.sv
// Scoreboard bench for store_merge_rmw: u0 runs with a 1-cycle memory, u1 with a 3-cycle memory.
module tb_store_merge_rmw;
    localparam int XLEN = 64;
    localparam int AW   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    store_merge_rmw_if #(.XLEN(XLEN), .AW(AW)) bif0 ();
    store_merge_rmw_if #(.XLEN(XLEN), .AW(AW)) bif1 ();

    store_merge_rmw #(.XLEN(XLEN), .AW(AW), .RD_LAT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bif0));
    store_merge_rmw #(.XLEN(XLEN), .AW(AW), .RD_LAT(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(bif1));

    typedef struct {
        int              cyc;
        logic            err;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] wdata;
    } done_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } rd_t;

    done_t dq0[$];
    done_t dq1[$];
    rd_t   rq0[$];
    rd_t   rq1[$];

    // Memory model: read data is only valid exactly RD_LAT cycles after the strobe.
    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return (a == 32'h100) ? 64'h1122_3344_5566_7788 : {32'hA5A5_0000, a};
    endfunction

    logic        p0_v = 1'b0;
    logic [63:0] p0_d = '0;
    logic [2:0]  p1_v = '0;
    logic [63:0] p1_d [3];

    always @(posedge clk) begin
        p0_v    <= bif0.mem_rd_en;
        p0_d    <= mem_word(bif0.mem_addr);
        p1_v    <= {p1_v[1:0], bif1.mem_rd_en};
        p1_d[2] <= p1_d[1];
        p1_d[1] <= p1_d[0];
        p1_d[0] <= mem_word(bif1.mem_addr);
    end

    assign bif0.mem_rdata = p0_v    ? p0_d    : 64'hDEAD_DEAD_DEAD_DEAD;
    assign bif1.mem_rdata = p1_v[2] ? p1_d[2] : 64'hDEAD_DEAD_DEAD_DEAD;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic rd, input logic wr, input logic dn, input logic er,
                       input logic [AW-1:0] addr, input logic [63:0] wd);
        string p;
        done_t d;
        rd_t   r;
        p = $sformatf("u%0d", k);
        if (rd || wr) chk({p, "_rd_wr_overlap"}, 64'(rd & wr), 64'd0);
        if (rd) begin
            if ((k == 0 ? rq0.size() : rq1.size()) == 0) begin
                chk({p, "_unexpected_rd"}, 64'(rd), 64'd0);
            end else begin
                r = (k == 0) ? rq0.pop_front() : rq1.pop_front();
                chk({p, "_rd_cycle"}, 64'(cyc), 64'(r.cyc));
                chk({p, "_rd_addr"}, 64'(addr), 64'(r.addr));
            end
        end
        if (wr && !dn) chk({p, "_wr_without_done"}, 64'(dn), 64'd1);
        if (dn) begin
            if ((k == 0 ? dq0.size() : dq1.size()) == 0) begin
                chk({p, "_unexpected_done"}, 64'(dn), 64'd0);
            end else begin
                d = (k == 0) ? dq0.pop_front() : dq1.pop_front();
                chk({p, "_done_cycle"}, 64'(cyc), 64'(d.cyc));
                chk({p, "_err"}, 64'(er), 64'(d.err));
                chk({p, "_wr_en"}, 64'(wr), 64'(!d.err));
                if (!d.err) begin
                    chk({p, "_wr_addr"}, 64'(addr), 64'(d.addr));
                    chk({p, "_wr_data"}, wd, d.wdata);
                end
                $display("u%0d done at cycle %0d err=%0b addr=0x%0h wdata=0x%016h",
                         k, cyc, er, addr, wd);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bif0.mem_rd_en, bif0.mem_wr_en, bif0.done, bif0.err, bif0.mem_addr, bif0.mem_wdata);
        mon(1, bif1.mem_rd_en, bif1.mem_wr_en, bif1.done, bif1.err, bif1.mem_addr, bif1.mem_wdata);
    end

    // Waits for ready, presents the request, and queues the hand-computed response.
    task automatic issue(input int k, input logic [AW-1:0] a, input logic [1:0] sz,
                         input logic [63:0] wd, input bit hold, input bit abandon,
                         input bit e_err, input bit e_rd, input logic [63:0] e_wd,
                         output int t);
        bit ok;
        int lat;
        done_t d;
        rd_t r;
        ok  = 1'b0;
        lat = (k == 0) ? 1 : 3;
        t   = cyc;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = (k == 0) ? bif0.req_ready : bif1.req_ready;
        end
        if (!ok) begin
            chk($sformatf("u%0d_ready_timeout", k), 64'(ok), 64'd1);
        end else begin
            if (k == 0) begin
                bif0.req_addr = a; bif0.req_size = sz; bif0.req_wdata = wd; bif0.req_valid = 1'b1;
            end else begin
                bif1.req_addr = a; bif1.req_size = sz; bif1.req_wdata = wd; bif1.req_valid = 1'b1;
            end
            t = cyc;
            r.cyc  = t + 1;
            r.addr = {a[AW-1:3], 3'b000};
            if (e_rd) begin
                if (k == 0) rq0.push_back(r); else rq1.push_back(r);
            end
            d.cyc   = (e_err || !e_rd) ? t + 1 : t + 2 + lat;
            d.err   = e_err;
            d.addr  = {a[AW-1:3], 3'b000};
            d.wdata = e_wd;
            if (!abandon) begin
                if (k == 0) dq0.push_back(d); else dq1.push_back(d);
            end
            $display("u%0d accept at cycle %0d addr=0x%0h size=%0d wdata=0x%016h",
                     k, t, a, sz, wd);
            @(posedge clk);
            #1;
            if (!hold) begin
                if (k == 0) bif0.req_valid = 1'b0; else bif1.req_valid = 1'b0;
            end
        end
    endtask

    task automatic chk_idle(input int k);
        string p;
        p = $sformatf("u%0d_idle", k);
        if (k == 0) begin
            chk({p, "_ready"}, 64'(bif0.req_ready), 64'd1);
            chk({p, "_rd_en"}, 64'(bif0.mem_rd_en), 64'd0);
            chk({p, "_wr_en"}, 64'(bif0.mem_wr_en), 64'd0);
            chk({p, "_done"},  64'(bif0.done), 64'd0);
            chk({p, "_err"},   64'(bif0.err), 64'd0);
            chk({p, "_addr"},  64'(bif0.mem_addr), 64'd0);
            chk({p, "_wdata"}, bif0.mem_wdata, 64'd0);
        end else begin
            chk({p, "_ready"}, 64'(bif1.req_ready), 64'd1);
            chk({p, "_rd_en"}, 64'(bif1.mem_rd_en), 64'd0);
            chk({p, "_wr_en"}, 64'(bif1.mem_wr_en), 64'd0);
            chk({p, "_done"},  64'(bif1.done), 64'd0);
            chk({p, "_err"},   64'(bif1.err), 64'd0);
            chk({p, "_addr"},  64'(bif1.mem_addr), 64'd0);
            chk({p, "_wdata"}, bif1.mem_wdata, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d",
                 compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t5, t6;
        bif0.req_valid = 1'b0; bif0.req_addr = '0; bif0.req_size = '0; bif0.req_wdata = '0;
        bif1.req_valid = 1'b0; bif1.req_addr = '0; bif1.req_size = '0; bif1.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle(0);
        chk_idle(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial stores through the 1-cycle memory, upper wdata bits deliberately dirty.
        issue(0, 32'h103, 2'd0, 64'h1234_5678_9ABC_DEAB, 0, 0, 0, 1, 64'h1122_3344_AB66_7788, t);
        issue(0, 32'h106, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF, 0, 0, 0, 1, 64'hBEEF_3344_5566_7788, t);
        issue(0, 32'h100, 2'd0, 64'h0000_0000_0000_00CC, 0, 0, 0, 1, 64'h1122_3344_5566_77CC, t);
        issue(0, 32'h100, 2'd2, 64'h0000_0000_0BAD_F00D, 0, 0, 0, 1, 64'h1122_3344_0BAD_F00D, t);
        // Full-word bypass.
        issue(0, 32'h108, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, t);
        // Misaligned word: error response, ready back two cycles after accept.
        issue(0, 32'h102, 2'd2, 64'h0000_0000_0BAD_F00D, 0, 0, 1, 0, 64'd0, t);
        @(negedge clk);
        chk("u0_err_ready_t1", 64'(bif0.req_ready), 64'd0);
        @(negedge clk);
        chk("u0_err_ready_t2", 64'(bif0.req_ready), 64'd1);
        issue(0, 32'h10C, 2'd3, 64'h1111_2222_3333_4444, 0, 0, 1, 0, 64'd0, t);
        issue(0, 32'h101, 2'd1, 64'h0000_0000_0000_5555, 0, 0, 1, 0, 64'd0, t);

        // 3-cycle memory: valid held through the busy period, next request queued behind it.
        issue(1, 32'h104, 2'd2, 64'hFFFF_FFFF_0BAD_F00D, 1, 0, 0, 1, 64'h0BAD_F00D_5566_7788, t5);
        issue(1, 32'h101, 2'd0, 64'h0000_0000_0000_005A, 0, 0, 0, 1, 64'h1122_3344_5566_5A88, t6);
        chk("u1_b2b_accept_cycle", 64'(t6), 64'(t5 + 6));
        issue(1, 32'h110, 2'd3, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, t);
        repeat (8) @(negedge clk);

        // Reset during WAIT abandons the store.
        issue(1, 32'h100, 2'd1, 64'h0000_0000_0000_1234, 0, 1, 0, 1, 64'd0, t);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(1, 32'h118, 2'd3, 64'hFEED_FACE_0000_0001, 0, 0, 0, 0, 64'hFEED_FACE_0000_0001, t);
        repeat (10) @(negedge clk);

        chk("u0_done_pending", 64'(dq0.size()), 64'd0);
        chk("u1_done_pending", 64'(dq1.size()), 64'd0);
        chk("u0_rd_pending", 64'(rq0.size()), 64'd0);
        chk("u1_rd_pending", 64'(rq1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
